seq_divrem: RTL and testbench
=============================

# seq_divrem

Parametrised, multi-cycle signed/unsigned divide-and-remainder unit. It generalises the 4-bit combinational `%` semantics to WIDTH-bit operands, adds a per-operation signedness mode, returns quotient and remainder together, and defines the divide-by-zero behaviour explicitly. It sits behind a valid/ready operand channel and in front of a valid/ready result channel, and passes an opaque tag through unchanged.

## Interface
- WIDTH, 8, operand/result width in bits, at least 2
- TAG_W, 4, width of the pass-through tag, at least 1

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand presented
- in_ready  out  1  unit idle and can accept an operand
- in_signed  in  1  1 = two's-complement operation, 0 = unsigned
- in_a  in  WIDTH  dividend
- in_b  in  WIDTH  divisor
- in_tag  in  TAG_W  opaque tag, returned with the result
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts the result
- out_quo  out  WIDTH  quotient
- out_rem  out  WIDTH  remainder
- out_div0  out  1  divisor was zero
- out_tag  out  TAG_W  tag captured at acceptance

## Operation
- States: IDLE, NORM, ITER, FIX, DONE.
- IDLE: in_ready=1. When in_valid is high at a clock edge, capture in_a, in_b, in_signed and in_tag, then go to NORM.
- NORM: in signed mode, take the magnitude of each operand and record the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)). Clear the WIDTH+1-bit partial remainder and the iteration counter. Go to ITER.
- ITER: perform one restoring step per cycle, MSB first: shift the partial remainder left, bring in the next dividend bit, trial-subtract |b|, keep the result if it is non-negative, and shift the resulting bit into the quotient. After exactly WIDTH steps, go to FIX.
- FIX: in signed mode, negate the quotient if the quotient sign is set, and negate the remainder if the remainder sign is set. The remainder takes the dividend's sign, as the SV `%` operator does. Go to DONE.
- DONE: out_valid=1 and all outputs are held stable. When out_ready is high at an edge, go to IDLE.
- Divide by zero: the latency is unchanged. The result is quo = all ones, rem = in_a (the original bits), div0 = 1.
- Signed MIN / -1: the quotient wraps to MIN, rem = 0, div0 = 0.
- All arithmetic is modulo 2^WIDTH. Negation is two's complement at WIDTH bits.
- No overlap: a new operand is not accepted while a result is outstanding.

## Timing
- Latency: out_valid rises exactly WIDTH+2 rising edges after the accepting edge, for every operand value including zero divisors.
- Minimum issue interval is WIDTH+3 cycles when out_ready is held high.
- in_ready is exactly (state == IDLE). It is combinational from state only, with no dependency on in_valid or out_ready.
- in_a, in_b and in_tag are don't-care outside the accepting edge.
- Reset (rst_n low, at any time, including mid-ITER or in DONE): state=IDLE, out_valid=0, out_quo=0, out_rem=0, out_div0=0, out_tag=0, in_ready=1. The in-flight operation is discarded. Operation resumes from the first rising edge after rst_n deasserts.
- Outputs are registered and change only on the FIX→DONE edge or on reset.

## Structure
- divrem_pkg holds:
  - the state enum `divrem_state_e`;
  - the function `neg_if(logic [WIDTH-1:0] v, logic s)`, parametrised via a class or a width-generic macro;
  - the divide-by-zero quotient constant.
- The sub-module divrem_step is purely combinational and implements one restoring step.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: next partial remainder, quotient bit.
- The top module holds the FSM, counter ($clog2(WIDTH+1) bits) and datapath registers.

## Test plan
All cases use WIDTH=4.
- Unsigned 13 / 4 -> quo=3, rem=1, div0=0, out_valid exactly 6 edges after acceptance.
- Signed -7 (4'b1001) / 2 -> quo=4'b1101 (-3), rem=4'b1111 (-1). Signed 7 / -2 -> quo=4'b1101 (-3), rem=1.
- Signed and unsigned 9 / 0 -> quo=4'hF, rem=4'h9, div0=1, same 6-edge latency.
- Signed -8 / -1 -> quo=4'b1000, rem=0, div0=0. Unsigned 4'b1000 / 4'hF -> quo=0, rem=8.
- Backpressure: hold out_ready low for 5 cycles in DONE -> outputs and out_tag stable, in_ready=0, and an in_valid pulse is ignored. Raise out_ready -> IDLE next edge, then back-to-back operands with tags 1, 2 return in order.
- Reset asserted during the 3rd ITER cycle -> all outputs 0 and in_ready=1 immediately. After release, 6 / 3 unsigned -> quo=2, rem=0 with the correct tag.
- Sweep all 2×256 operand pairs -> quo and rem match SV `/` and `%` for b≠0; the divide-by-zero rule holds for b=0.

Source files
------------

// File: rtl/divrem_pkg.sv
// Shared types, constants and helpers for the sequential divide/remainder unit.

`ifndef DIVREM_PKG_NEG_IF
`define DIVREM_PKG_NEG_IF
// Width-generic conditional two's-complement negation: NEG_IF(width, value, negate)
`define NEG_IF(w, v, s) ((s) ? w'(~(v) + w'(1)) : (v))
`endif

package divrem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NORM = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } divrem_state_e;

  // Divide-by-zero quotient is this bit replicated across the result width.
  localparam logic DIV0_QUO_BIT = 1'b1;

endpackage

// File: rtl/divrem_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.

module divrem_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dbit_in,
  input  logic [WIDTH-1:0] div_in,
  output logic [WIDTH:0]   rem_out,
  output logic             qbit_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // rem_in is always below the divisor, so one extra bit is enough to see the borrow.
  always_comb begin
    shifted  = {rem_in, dbit_in};
    diff     = shifted - {2'b00, div_in};
    qbit_out = ~diff[WIDTH+1];
    rem_out  = qbit_out ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_divrem.sv
// Multi-cycle signed/unsigned divider returning quotient and remainder behind valid/ready channels.

module seq_divrem
  import divrem_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quo,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_div0,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  divrem_state_e    state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;          // dividend magnitude, becomes quotient as it shifts
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] orig_a_q, orig_a_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_quo_q, out_quo_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic             out_div0_q, out_div0_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic [WIDTH:0]   step_rem;
  logic             step_qbit;

  divrem_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (rem_q),
    .dbit_in  (a_q[WIDTH-1]),
    .div_in   (b_q),
    .rem_out  (step_rem),
    .qbit_out (step_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      orig_a_q    <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_quo_q   <= '0;
      out_rem_q   <= '0;
      out_div0_q  <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      orig_a_q    <= orig_a_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      out_quo_q   <= out_quo_d;
      out_rem_q   <= out_rem_d;
      out_div0_q  <= out_div0_d;
      out_tag_q   <= out_tag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    orig_a_d    = orig_a_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    sgn_d       = sgn_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    tag_d       = tag_q;
    out_valid_d = out_valid_q;
    out_quo_d   = out_quo_q;
    out_rem_d   = out_rem_q;
    out_div0_d  = out_div0_q;
    out_tag_d   = out_tag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          orig_a_d = in_a;
          sgn_d    = in_signed;
          tag_d    = in_tag;
          state_d  = ST_NORM;
        end
      end
      ST_NORM: begin
        a_d     = `NEG_IF(WIDTH, a_q, sgn_q & a_q[WIDTH-1]);
        b_d     = `NEG_IF(WIDTH, b_q, sgn_q & b_q[WIDTH-1]);
        qneg_d  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d  = sgn_q & a_q[WIDTH-1];
        rem_d   = '0;
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        rem_d = step_rem;
        a_d   = {a_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        out_valid_d = 1'b1;
        out_tag_d   = tag_q;
        // Zero divisor overrides the iterated result with fixed values.
        if (b_q == '0) begin
          out_quo_d  = {WIDTH{DIV0_QUO_BIT}};
          out_rem_d  = orig_a_q;
          out_div0_d = 1'b1;
        end else begin
          out_quo_d  = `NEG_IF(WIDTH, a_q, qneg_q);
          out_rem_d  = `NEG_IF(WIDTH, rem_q[WIDTH-1:0], rneg_q);
          out_div0_d = 1'b0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_quo   = out_quo_q;
  assign out_rem   = out_rem_q;
  assign out_div0  = out_div0_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_seq_divrem.sv
// Self-checking bench for seq_divrem at WIDTH=4 against an integer-arithmetic reference model.

module tb_seq_divrem;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned TAG_W = 4;
  localparam int LAT = WIDTH + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_signed = 1'b0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_quo;
  logic [WIDTH-1:0] out_rem;
  logic             out_div0;
  logic [TAG_W-1:0] out_tag;

  int tests = 0;
  int fails = 0;

  seq_divrem #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quo   (out_quo),
    .out_rem   (out_rem),
    .out_div0  (out_div0),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer division, truncated to WIDTH bits.
  function automatic void model(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                output logic d0);
    int sa;
    int sb;
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    if (sb == 0) begin
      q  = '1;
      r  = a;
      d0 = 1'b1;
    end else begin
      q  = WIDTH'(sa / sb);
      r  = WIDTH'(sa % sb);
      d0 = 1'b0;
    end
  endfunction

  task automatic issue(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [TAG_W-1:0] tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("issue_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_signed = s;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = WIDTH'($urandom);
    in_b     = WIDTH'($urandom);
    in_tag   = TAG_W'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string name, input logic s, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             d0;
    model(s, a, b, q, r, d0);
    check_eq({name, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({name, "_quo"}, 32'(out_quo), 32'(q));
    check_eq({name, "_rem"}, 32'(out_rem), 32'(r));
    check_eq({name, "_div0"}, 32'(out_div0), 32'(d0));
    check_eq({name, "_tag"}, 32'(out_tag), 32'(tag));
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("release_valid", 32'(out_valid), 32'd0);
    check_eq("release_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string name, input logic s, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    int lat;
    issue(s, a, b, tag);
    wait_result(lat);
    check_eq({name, "_latency"}, 32'(lat), 32'(LAT));
    check_result(name, s, a, b, tag);
    release_out();
  endtask

  initial begin
    int lat;

    // Reset state
    #12;
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_quo", 32'(out_quo), 32'd0);
    check_eq("rst_rem", 32'(out_rem), 32'd0);
    check_eq("rst_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op("u13_4", 1'b0, 4'd13, 4'd4, 4'd3);
    run_op("s_m7_2", 1'b1, 4'b1001, 4'd2, 4'd4);
    run_op("s_7_m2", 1'b1, 4'd7, 4'b1110, 4'd5);
    run_op("s9_0", 1'b1, 4'd9, 4'd0, 4'd6);
    run_op("u9_0", 1'b0, 4'd9, 4'd0, 4'd7);
    run_op("s_min_m1", 1'b1, 4'b1000, 4'hF, 4'd8);
    run_op("u8_15", 1'b0, 4'b1000, 4'hF, 4'd9);

    // Backpressure: result held in DONE, in_valid ignored
    issue(1'b0, 4'd11, 4'd3, 4'hA);
    wait_result(lat);
    check_eq("bp_latency", 32'(lat), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        in_valid = 1'b1;
        in_a     = 4'd15;
        in_b     = 4'd1;
        in_tag   = 4'hC;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check_result("bp_hold", 1'b0, 4'd11, 4'd3, 4'hA);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    run_op("b2b_1", 1'b0, 4'd14, 4'd5, 4'd1);
    run_op("b2b_2", 1'b1, 4'b1010, 4'd3, 4'd2);

    // Reset during the third ITER cycle
    issue(1'b0, 4'd13, 4'd3, 4'hE);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_quo", 32'(out_quo), 32'd0);
    check_eq("mid_rst_rem", 32'(out_rem), 32'd0);
    check_eq("mid_rst_div0", 32'(out_div0), 32'd0);
    check_eq("mid_rst_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_6_3", 1'b0, 4'd6, 4'd3, 4'hB);

    // Full sweep, both modes, random tags
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          run_op("sweep", 1'(s), 4'(a), 4'(b), TAG_W'($urandom));
        end
      end
    end

    // Random operands with random backpressure
    for (int k = 0; k < 60; k++) begin
      logic             s;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAG_W-1:0] t;
      s = 1'($urandom);
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      t = TAG_W'($urandom);
      issue(s, a, b, t);
      wait_result(lat);
      check_eq("rand_latency", 32'(lat), 32'(LAT));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      check_result("rand", s, a, b, t);
      release_out();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
